// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/data requesters, the arbiter and the memory bus.
// Handshake: a requester raises *Req with stable address/data and holds it until its *Done
// pulse; the bus side sees busReq with stable fields until busAck (one cycle) or the arbiter times out.
interface mem_port_arbiter_if;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic [31:0] ifRdata;
  logic        ifDone;
  logic        dReq;
  logic        dWrite;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [1:0]  dMode;
  logic [31:0] dRdata;
  logic        dDone;
  logic        busReq;
  logic        busWrite;
  logic [31:0] busAddr;
  logic [31:0] busWdata;
  logic [1:0]  busMode;
  logic [31:0] busRdata;
  logic        busAck;
  logic        busErr;
  logic        ifStall;
  logic        dStall;

  modport slave (
    input  ifReq, ifAddr, dReq, dWrite, dAddr, dWdata, dMode, busRdata, busAck,
    output ifRdata, ifDone, dRdata, dDone, busReq, busWrite, busAddr, busWdata,
           busMode, busErr, ifStall, dStall
  );

  modport master (
    output ifReq, ifAddr, dReq, dWrite, dAddr, dWdata, dMode, busRdata, busAck,
    input  ifRdata, ifDone, dRdata, dDone, busReq, busWrite, busAddr, busWdata,
           busMode, busErr, ifStall, dStall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter with bus-wait timeout; state moves on negedge clk.
// Optional macro ARB_FAIR_EN: alternate grants when both requesters are pending.
module mem_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    port,
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_D  = 2'd2,
    RESP     = 2'd3
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wait_cnt;
  logic        owner_d;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic [1:0]  mode_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic        in_grant;
  logic        timed_out;
  logic        pick_d;

  assign in_grant  = (state == GRANT_IF) || (state == GRANT_D);
  assign timed_out = in_grant && !port.busAck && (wait_cnt == WAIT_LAST);
  assign fsm_state = state;

`ifdef ARB_FAIR_EN
  logic last_was_d;

  // Fetch wins a tie only right after a data grant.
  assign pick_d = port.dReq && !(port.ifReq && last_was_d);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_was_d <= 1'b0;
    end else if (state == IDLE) begin
      if (state_nxt == GRANT_D)       last_was_d <= 1'b1;
      else if (state_nxt == GRANT_IF) last_was_d <= 1'b0;
    end
  end
`else
  assign pick_d = port.dReq;
`endif

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_d)           state_nxt = GRANT_D;
        else if (port.ifReq)  state_nxt = GRANT_IF;
      end
      GRANT_IF, GRANT_D: begin
        if (port.busAck || timed_out) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      mode_q     <= '0;
      owner_d    <= 1'b0;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (state_nxt == GRANT_D) begin
            addr_q   <= port.dAddr;
            wdata_q  <= port.dWdata;
            write_q  <= port.dWrite;
            mode_q   <= port.dMode;
            owner_d  <= 1'b1;
            err_q    <= 1'b0;
            wait_cnt <= '0;
          end else if (state_nxt == GRANT_IF) begin
            addr_q   <= port.ifAddr;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            mode_q   <= 2'b10;
            owner_d  <= 1'b0;
            err_q    <= 1'b0;
            wait_cnt <= '0;
          end
        end
        GRANT_IF, GRANT_D: begin
          if (port.busAck) begin
            if (!owner_d)      if_rdata_q <= port.busRdata;
            else if (!write_q) d_rdata_q  <= port.busRdata;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            // An aborted read returns zero; an aborted store keeps dRdata untouched.
            if (timed_out) begin
              err_q <= 1'b1;
              if (!owner_d)      if_rdata_q <= '0;
              else if (!write_q) d_rdata_q  <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    port.busReq   = in_grant;
    port.busWrite = write_q;
    port.busAddr  = addr_q;
    port.busWdata = wdata_q;
    port.busMode  = mode_q;
    port.ifRdata  = if_rdata_q;
    port.dRdata   = d_rdata_q;
    port.ifDone   = (state == RESP) && !owner_d;
    port.dDone    = (state == RESP) && owner_d;
    port.busErr   = (state == RESP) && err_q;
    port.ifStall  = port.ifReq && !port.ifDone;
    port.dStall   = port.dReq && !port.dDone;
  end

endmodule
